// File: rtl/dht11_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dht11_bus_master_pkg
// Description : Shared definitions for the DHT11 single-wire bus master:
//               FSM state encoding, frame geometry, default timing constants
//               and the frame checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dht11_bus_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_WAIT_ACK  = 4'd2,
    ST_ACK_LOW   = 4'd3,
    ST_ACK_HIGH  = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_CHECK     = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERR       = 4'd9
  } state_t;

  localparam int FRAME_BITS = 40;
  localparam int BIT_CNT_W  = 6;
  localparam int CNT_W      = 15;

  localparam int DEF_START_LOW_US     = 18000;
  localparam int DEF_TIMEOUT_US       = 255;
  localparam int DEF_BIT_THRESHOLD_US = 40;

  // Byte 4 must equal the 8-bit sum of bytes 0..3 (bit 0 = first received,
  // i.e. MSB of byte 0).
  function automatic logic checksum_ok(input logic [0:FRAME_BITS-1] f);
    logic [7:0] sum;
    sum = f[0:7] + f[8:15] + f[16:23] + f[24:31];
    return (sum == f[32:39]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_bus_master_pin_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : pin_synchronizer
// Description : Two-flop synchronizer for the asynchronous DHT11 data line.
// Ports       : clk_1mhz  - 1 MHz clock
//               reset     - synchronous active-high reset (flops clear to 0)
//               i_pin     - raw line value
//               o_pin_s   - synchronized line value (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module pin_synchronizer (
  input  logic clk_1mhz,
  input  logic reset,
  input  logic i_pin,
  output logic o_pin_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  assign o_pin_s = r_sync;

endmodule
`default_nettype wire

// File: rtl/dht11_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : dht11_bus_master
// Description : DHT11 single-wire bus master. Issues the host start pulse,
//               follows the sensor ACK, times 40 data bits, verifies the
//               checksum and publishes the frame.
// Ports       : clk_1mhz     - 1 MHz clock, one cycle = 1 us
//               reset        - synchronous active-high reset
//               start_sensor - one-cycle read request (ignored while busy)
//               sensor_pin   - open-drain data line (driven 0 or released)
//               sensor_data  - last good frame, [0] = first bit received
//               busy         - transaction in progress
//               done         - one-cycle pulse on a checksum-valid frame
//               error        - sticky timeout/checksum error flag
// Revision    : 1.0 - initial release
// ============================================================================
module dht11_bus_master
  import dht11_bus_master_pkg::*;
#(
  parameter int START_LOW_US     = DEF_START_LOW_US,
  parameter int TIMEOUT_US       = DEF_TIMEOUT_US,
  parameter int BIT_THRESHOLD_US = DEF_BIT_THRESHOLD_US
) (
  input  logic                  clk_1mhz,
  input  logic                  reset,
  input  logic                  start_sensor,
  inout  wire                   sensor_pin,
  output logic [0:FRAME_BITS-1] sensor_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // A phase times out on the edge where the counter would reach TIMEOUT_US,
  // so ERR is entered exactly TIMEOUT_US cycles after the phase began.
  localparam logic [CNT_W-1:0] c_START_LAST = CNT_W'(START_LOW_US - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT    = CNT_W'(TIMEOUT_US - 1);
  // The counter reads (high_time - 1) when the falling edge is seen, so
  // "high time > threshold" becomes "count >= threshold".
  localparam logic [CNT_W-1:0] c_BIT_THRESH = CNT_W'(BIT_THRESHOLD_US);
  localparam logic [BIT_CNT_W-1:0] c_LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_CNT_W-1:0]  r_bits;
  logic [0:FRAME_BITS-1] r_shift;
  logic                  r_pin_d;
  logic                  w_pin_s;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_timeout;
  logic                  w_drive_low;

  pin_synchronizer u_sync (
    .clk_1mhz (clk_1mhz),
    .reset    (reset),
    .i_pin    (sensor_pin),
    .o_pin_s  (w_pin_s)
  );

  assign w_rise    = w_pin_s & ~r_pin_d;
  assign w_fall    = ~w_pin_s & r_pin_d;
  assign w_timeout = (r_cnt == c_TIMEOUT);

  // Reset releases the line combinationally, in the very cycle it is seen.
  assign w_drive_low = (r_state == ST_START_LOW) && !reset;
  assign sensor_pin  = w_drive_low ? 1'b0 : 1'bz;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start_sensor) w_next = ST_START_LOW;
      ST_START_LOW: if (r_cnt == c_START_LAST) w_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (w_fall) w_next = ST_ACK_LOW;
                    else if (w_timeout) w_next = ST_ERR;
      ST_ACK_LOW:   if (w_rise) w_next = ST_ACK_HIGH;
                    else if (w_timeout) w_next = ST_ERR;
      ST_ACK_HIGH:  if (w_fall) w_next = ST_BIT_LOW;
                    else if (w_timeout) w_next = ST_ERR;
      ST_BIT_LOW:   if (w_rise) w_next = ST_BIT_HIGH;
                    else if (w_timeout) w_next = ST_ERR;
      ST_BIT_HIGH:  if (w_fall) w_next = (r_bits == c_LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
                    else if (w_timeout) w_next = ST_ERR;
      ST_CHECK:     w_next = checksum_ok(r_shift) ? ST_DONE : ST_ERR;
      ST_DONE:      w_next = ST_IDLE;
      ST_ERR:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      r_pin_d     <= 1'b0;
      sensor_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pin_d <= w_pin_s;
      done    <= 1'b0;

      // Shared duration counter: clears on any state change, saturates.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (start_sensor) begin
            error   <= 1'b0;
            busy    <= 1'b1;
            r_bits  <= '0;
            r_shift <= '0;
          end
        end
        ST_BIT_HIGH: begin
          if (w_fall) begin
            r_shift <= {r_shift[1:FRAME_BITS-1], (r_cnt >= c_BIT_THRESH)};
            r_bits  <= r_bits + 1'b1;
          end
        end
        ST_DONE: begin
          sensor_data <= r_shift;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        ST_ERR:  busy <= 1'b0;
        default: ;
      endcase

      if (w_next == ST_ERR && r_state != ST_ERR) error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dht11_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dht11_bus_master
// Description : Directed bench for dht11_bus_master with a DHT11 line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_bus_master;

  logic        clk_1mhz = 1'b0;
  logic        reset;
  logic        start_sensor;
  logic        sensor_low;
  wire         sensor_pin;
  logic [0:39] sensor_data;
  logic        busy;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;

  assign sensor_pin = sensor_low ? 1'b0 : 1'bz;
  pullup (sensor_pin);

  always #500 clk_1mhz = ~clk_1mhz;

  always @(negedge clk_1mhz) if (done === 1'b1) done_pulses++;

  dht11_bus_master dut (
    .clk_1mhz     (clk_1mhz),
    .reset        (reset),
    .start_sensor (start_sensor),
    .sensor_pin   (sensor_pin),
    .sensor_data  (sensor_data),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // Sensor model: host start, 20 us turnaround, 80/80 us ACK, then 40 bits of
  // 50 us low + data-high. With vary set, odd bits use the 40/41 us boundary
  // widths. With poke set, start_sensor is pulsed during bit 10's low phase.
  // Returns with the line pulled low (final falling edge just driven).
  task automatic run_frame(input logic [39:0] frame, input bit vary, input bit poke,
                           output bit ok, output logic err_at_start, output logic busy_at_start);
    int n;
    int h;
    ok = 1'b1;
    start_sensor = 1'b1;
    @(negedge clk_1mhz);
    start_sensor = 1'b0;
    err_at_start  = error;
    busy_at_start = busy;
    n = 0;
    while (sensor_pin !== 1'b0 && n < 5) begin @(negedge clk_1mhz); n++; end
    if (n >= 5) ok = 1'b0;
    n = 0;
    while (sensor_pin === 1'b0 && n < 20000) begin @(negedge clk_1mhz); n++; end
    if (n >= 20000) ok = 1'b0;
    repeat (20) @(negedge clk_1mhz);
    sensor_low = 1'b1;
    repeat (80) @(negedge clk_1mhz);
    sensor_low = 1'b0;
    repeat (80) @(negedge clk_1mhz);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      if (poke && i == 10) begin
        @(negedge clk_1mhz);
        start_sensor = 1'b1;
        @(negedge clk_1mhz);
        start_sensor = 1'b0;
        repeat (48) @(negedge clk_1mhz);
      end else begin
        repeat (50) @(negedge clk_1mhz);
      end
      sensor_low = 1'b0;
      if (frame[39-i]) h = (vary && (i % 2 == 1)) ? 41 : 70;
      else             h = (vary && (i % 2 == 1)) ? 40 : 26;
      repeat (h) @(negedge clk_1mhz);
    end
    sensor_low = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_sensor = 1'b0;
    sensor_low = 1'b0;
    repeat (3) @(negedge clk_1mhz);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    tests++; if (sensor_data !== 40'h0) begin fails++; $display("FAIL reset_data: got %h want 0", sensor_data); end
    tests++; if (sensor_pin !== 1'b1) begin fails++; $display("FAIL reset_pin: got %b want 1", sensor_pin); end
    reset = 1'b0;
    @(negedge clk_1mhz);
  endtask

  task automatic test_reset_in_start_low();
    int n;
    start_sensor = 1'b1;
    @(negedge clk_1mhz);
    start_sensor = 1'b0;
    n = 0;
    while (sensor_pin === 1'b0 && n < 5000) begin @(negedge clk_1mhz); n++; end
    tests++; if (n !== 5000 || sensor_pin !== 1'b0)
      begin fails++; $display("FAIL start_low_5000: got %0d low cycles want 5000", n); end
    reset = 1'b1;
    @(negedge clk_1mhz);
    tests++; if (sensor_pin !== 1'b1) begin fails++; $display("FAIL midreset_pin: got %b want 1", sensor_pin); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if (error !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL midreset_flags: got err=%b done=%b want 0 0", error, done); end
    tests++; if (sensor_data !== 40'h0) begin fails++; $display("FAIL midreset_data: got %h want 0", sensor_data); end
    reset = 1'b0;
    @(negedge clk_1mhz);
  endtask

  task automatic test_no_response();
    int n;
    start_sensor = 1'b1;
    @(negedge clk_1mhz);
    start_sensor = 1'b0;
    n = 0;
    while (sensor_pin === 1'b0 && n < 20000) begin n++; @(negedge clk_1mhz); end
    tests++; if (n !== 18000) begin fails++; $display("FAIL start_low_len: got %0d want 18000", n); end
    n = 0;
    while (error !== 1'b1 && n < 400) begin @(negedge clk_1mhz); n++; end
    tests++; if (n !== 255) begin fails++; $display("FAIL ack_timeout: got %0d cycles want 255", n); end
    @(negedge clk_1mhz);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b want 1", error); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b want 0", busy); end
    tests++; if (sensor_pin !== 1'b1) begin fails++; $display("FAIL timeout_pin: got %b want 1", sensor_pin); end
    repeat (10) @(negedge clk_1mhz);
  endtask

  task automatic test_good_frame();
    bit   ok;
    logic e0;
    logic b0;
    int   d0;
    d0 = done_pulses;
    run_frame(40'h3700190050, 1'b1, 1'b1, ok, e0, b0);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL good_host_start: got %b want 1", ok); end
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL good_err_clear: got %b want 0", e0); end
    tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL good_busy_set: got %b want 1", b0); end
    repeat (4) @(negedge clk_1mhz);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL good_done_early: got %b want 0", done); end
    @(negedge clk_1mhz);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL good_done_lat5: got %b want 1", done); end
    tests++; if (sensor_data !== 40'h3700190050)
      begin fails++; $display("FAIL good_data: got %h want 3700190050", sensor_data); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL good_error: got %b want 0", error); end
    @(negedge clk_1mhz);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL good_done_width: got %b want 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL good_busy_clear: got %b want 0", busy); end
    repeat (40) @(negedge clk_1mhz);
    sensor_low = 1'b0;
    repeat (10) @(negedge clk_1mhz);
    tests++; if (done_pulses - d0 !== 1)
      begin fails++; $display("FAIL good_done_count: got %0d want 1", done_pulses - d0); end
  endtask

  task automatic test_bad_checksum();
    bit   ok;
    logic e0;
    logic b0;
    int   d0;
    d0 = done_pulses;
    run_frame(40'h3700190051, 1'b0, 1'b0, ok, e0, b0);
    tests++; if (ok !== 1'b1 || b0 !== 1'b1)
      begin fails++; $display("FAIL bad_host_start: got ok=%b busy=%b want 1 1", ok, b0); end
    repeat (8) @(negedge clk_1mhz);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL bad_error: got %b want 1", error); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_busy: got %b want 0", busy); end
    tests++; if (sensor_data !== 40'h3700190050)
      begin fails++; $display("FAIL bad_data_kept: got %h want 3700190050", sensor_data); end
    sensor_low = 1'b0;
    repeat (20) @(negedge clk_1mhz);
    tests++; if (done_pulses !== d0)
      begin fails++; $display("FAIL bad_no_done: got %0d pulses want 0", done_pulses - d0); end
  endtask

  initial begin
    test_reset();
    test_reset_in_start_low();
    test_no_response();
    test_good_frame();
    test_bad_checksum();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dht11_bus_master.md
DHT11_BUS_MASTER -- requirements
Module: dht11_bus_master

Interface
REQ-001 Parameter START_LOW_US, 18000, host start-pulse length in clk_1mhz cycles.
REQ-002 Parameter TIMEOUT_US, 255, maximum length of any sensor-driven phase before an error.
REQ-003 Parameter BIT_THRESHOLD_US, 40, bit-high length above which a data bit is 1.
REQ-004 clk_1mhz  input  1  sole clock, 1 MHz; one cycle = 1 us.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_sensor  input  1  one-cycle read request from sensor_controller.
REQ-007 sensor_pin  inout  1  open-drain DHT11 data line: driven 0 or released (Z), never driven 1.
REQ-008 sensor_data  output  [0:39]  last good frame; sensor_data[0] = first bit received.
REQ-009 busy  output  1  high from accepted start to DONE/ERR exit.
REQ-010 done  output  1  one-cycle pulse when a frame passes checksum.
REQ-011 error  output  1  sticky level for a timeout or bad checksum; cleared by the next accepted start.

Function
REQ-012 sensor_pin SHALL pass through a 2-flop synchronizer (pin_s); all timing SHALL use pin_s edges, giving a fixed 2-cycle measurement offset.
REQ-013 FSM states: IDLE, START_LOW, WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE, ERR.
REQ-014 IDLE: on start_sensor, go to START_LOW, clear error, set busy, and clear the bit counter and shift register.
REQ-015 start_sensor SHALL be ignored while busy is high.
REQ-016 START_LOW: drive the line 0 for exactly START_LOW_US cycles, then release it and go to WAIT_ACK.
REQ-017 WAIT_ACK: a falling edge on pin_s goes to ACK_LOW; a rising edge in ACK_LOW goes to ACK_HIGH; a falling edge in ACK_HIGH goes to BIT_LOW.
REQ-018 BIT_LOW: a rising edge on pin_s goes to BIT_HIGH with the duration counter cleared.
REQ-019 BIT_HIGH: on a falling edge, shift in 1 if the measured high time > BIT_THRESHOLD_US, else 0, and increment the bit counter.
REQ-020 BIT_HIGH exit: after the 40th bit go to CHECK; otherwise go to BIT_LOW.
REQ-021 A 40th bit ending in a timeout (the line stays high) SHALL be an error.
REQ-022 In WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW and BIT_HIGH, a duration counter reaching TIMEOUT_US without the expected edge SHALL go to ERR.
REQ-023 CHECK: byte4 SHALL equal (byte0+byte1+byte2+byte3) mod 256, with byte0 = bits[0:7]; on a match go to DONE, otherwise go to ERR.
REQ-024 DONE: load sensor_data from the shift register, pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-025 ERR: set error, leave sensor_data unchanged, clear busy, and return to IDLE.
REQ-026 The line SHALL be released in every state except START_LOW.
REQ-027 The shared duration counter SHALL be 15 bits, saturate rather than wrap, and clear on every state change.
REQ-028 Latency from the final falling edge on the pin to the done pulse SHALL be 2 (synchronizer) + 1 (BIT_HIGH) + 1 (CHECK) + 1 (DONE) = 5 cycles.
REQ-029 The 1 s minimum inter-read spacing SHALL NOT be enforced here; it is sensor_controller's responsibility.

Reset
REQ-030 On reset: state IDLE, line released, sensor_data = 0, busy = 0, done = 0, error = 0, and counters and synchronizer = 0.
REQ-031 Reset mid-transaction SHALL release the line in the same cycle it is sampled, and the interrupted frame SHALL be discarded.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the frame width (40), and the default timing constants.
REQ-033 Sub-module pin_synchronizer SHALL hold the 2-flop synchronizer; everything else SHALL be in one FSM/datapath block.

Verification
REQ-034 Good frame 0x37,0x00,0x19,0x00,0x50, with the sensor model at 80/80 us ACK, 50 us low, 26 us = 0 and 70 us = 1 -> sensor_data = 0x3700190050, one done pulse, error = 0.
REQ-035 Same frame with checksum byte 0x51 -> error = 1, no done, sensor_data keeps its prior value.
REQ-036 No sensor response after start -> error asserted exactly TIMEOUT_US cycles after entering WAIT_ACK, and the line is released.
REQ-037 start_sensor pulsed again at bit 10 of a transfer -> ignored, and the frame completes normally.
REQ-038 reset asserted during START_LOW at cycle 5000 -> line released the next cycle, all outputs 0; a new start gives a full 18000-cycle low.
REQ-039 Bit-high boundary: 40 us -> 0, 41 us -> 1 (pin-referenced, after the synchronizer offset), and the sequence error, then good read -> error clears at the start and done pulses.
